// File: rtl/timer_apb_pkg.sv
// Shared FSM encoding and register map for the timer APB slave.
// APB_WAIT_STATE_EN adds the WAIT state to the FSM encoding.
package timer_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1
`ifdef APB_WAIT_STATE_EN
    ,
    ST_WAIT   = 2'd2
`endif
  } state_e;

  localparam logic [11:0] TCR   = 12'h00;
  localparam logic [11:0] TDR0  = 12'h04;
  localparam logic [11:0] TDR1  = 12'h08;
  localparam logic [11:0] TCMP0 = 12'h0C;
  localparam logic [11:0] TCMP1 = 12'h10;
  localparam logic [11:0] TIER  = 12'h14;
  localparam logic [11:0] TISR  = 12'h18;
  localparam logic [11:0] THCSR = 12'h1C;

  localparam logic [11:0] REG_MAX_OFFSET = THCSR;

endpackage

// File: rtl/apb_slave_ctrl.sv
// APB slave front end for the timer register file: FSM, address decode, error counter.
// Define APB_WAIT_STATE_EN to insert one wait state before every access completes.
//
// Handshake: a transfer completes in the single cycle where pready=1; wr_en/rd_en
// and pslverr are only ever asserted in that cycle, and prdata is zero otherwise.
module apb_slave_ctrl
  import timer_apb_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MAX_OFFSET = ADDR_W'(REG_MAX_OFFSET)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata,
  output logic              wr_en,
  output logic              rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              tim_pslverr,
  output logic [7:0]        err_cnt,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [3:0]        reg_pstrb,
  output state_e            state_dbg
);

  state_e     state_q, state_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       addr_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Dropping psel always returns to IDLE; penable without a setup cycle is ignored.
  always_comb begin
    state_d = state_q;
    if (!psel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!penable) begin
`ifdef APB_WAIT_STATE_EN
            state_d = ST_WAIT;
`else
            state_d = ST_ACCESS;
`endif
          end
        end
`ifdef APB_WAIT_STATE_EN
        ST_WAIT:   state_d = ST_ACCESS;
`endif
        ST_ACCESS: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_err  = (paddr[1:0] != 2'b00) || (paddr > MAX_OFFSET);
    pready    = rst_n && (state_q == ST_ACCESS) && psel && penable;
    wr_en     = pready && pwrite && !addr_err;
    rd_en     = pready && !pwrite && !addr_err;
    prdata    = rd_en ? reg_rdata : '0;
    pslverr   = pready && (addr_err || (pwrite && tim_pslverr));
    reg_wdata = wr_en ? pwdata : '0;
    reg_pstrb = wr_en ? pstrb : 4'h0;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pready && pslverr && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench for apb_slave_ctrl: vector table plus hand-written corner sequences.
// Build with or without APB_WAIT_STATE_EN; expected latencies follow the macro.
module tb_apb_slave_ctrl;
  import timer_apb_pkg::*;

`ifdef APB_WAIT_STATE_EN
  localparam int WAIT_CYC = 1;
  localparam int B2B_GAP  = 3;
`else
  localparam int WAIT_CYC = 0;
  localparam int B2B_GAP  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, reg_rdata;
  logic [3:0]  pstrb;
  logic        tim_pslverr;
  logic        pready, pslverr, wr_en, rd_en;
  logic [31:0] prdata, reg_wdata;
  logic [7:0]  err_cnt;
  logic [3:0]  reg_pstrb;
  state_e      state_dbg;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_pready_cyc = 0;
  int          last_gap = 0;
  logic [7:0]  exp_err = 8'd0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          tim_err;
    bit          exp_wr;
    bit          exp_rd;
    bit          exp_err;
    logic [31:0] exp_prdata;
  } vec_t;

  vec_t vecs[9];

  apb_slave_ctrl dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .pslverr(pslverr), .prdata(prdata), .wr_en(wr_en), .rd_en(rd_en),
    .reg_rdata(reg_rdata), .tim_pslverr(tim_pslverr), .err_cnt(err_cnt),
    .reg_wdata(reg_wdata), .reg_pstrb(reg_pstrb), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
      check("idle_pready", 32'(pready), 32'd0);
      check("idle_prdata", prdata, 32'd0);
      check("idle_err_cnt", 32'(err_cnt), 32'(exp_err));
    end
  endtask

  task automatic xfer(input vec_t v);
    int waits;
    bit seen;
    logic [31:0] exp_data;
    exp_q.push_back(v.exp_prdata);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.wdata; pstrb = v.strb; reg_rdata = v.rdata; tim_pslverr = v.tim_err;
    @(negedge clk);
    check("setup_pready", 32'(pready), 32'd0);
    check("setup_strobe", 32'({wr_en, rd_en, pslverr}), 32'd0);
    check("setup_prdata", prdata, 32'd0);
    check("setup_err_cnt", 32'(err_cnt), 32'(exp_err));
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    seen  = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (pready) begin
        seen = 1'b1;
      end else begin
        waits++;
        check("wait_strobe", 32'({wr_en, rd_en, pslverr}), 32'd0);
        check("wait_prdata", prdata, 32'd0);
      end
    end
    check("pready_seen", 32'(seen), 32'd1);
    exp_data = exp_q.pop_front();
    if (seen) begin
      check("wait_cycles", 32'(waits), 32'(WAIT_CYC));
      last_gap        = cyc - last_pready_cyc;
      last_pready_cyc = cyc;
      check("wr_en", 32'(wr_en), 32'(v.exp_wr));
      check("rd_en", 32'(rd_en), 32'(v.exp_rd));
      check("pslverr", 32'(pslverr), 32'(v.exp_err));
      check("prdata", prdata, exp_data);
      check("reg_pstrb", 32'(reg_pstrb), v.exp_wr ? 32'(v.strb) : 32'd0);
      check("reg_wdata", reg_wdata, v.exp_wr ? v.wdata : 32'd0);
      if (v.exp_err && (exp_err != 8'hFF)) exp_err = exp_err + 8'd1;
    end
  endtask

  initial begin
    vec_t wv, rv, ev;
    rst_n = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    paddr = 12'h004; pwdata = '0; pstrb = 4'h0; reg_rdata = 32'hAAAA_5555;
    tim_pslverr = 1'b0;

    //             wr    addr    wdata         strb  rdata         terr  ewr   erd   eerr  eprdata
    vecs[0] = '{1'b1, 12'h00C, 32'h1234_5678, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 12'h004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 12'h000, 32'h0000_00FF, 4'hF, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 12'h022, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 12'h005, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 12'h01C, 32'hA5A5_0101, 4'h5, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 12'h020, 32'h1111_2222, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 12'h01C, 32'h0,         4'hA, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE};
    vecs[8] = '{1'b1, 12'h010, 32'h7654_3210, 4'h3, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

    // Reset with an apparent access on the bus: everything held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_strobe", 32'({wr_en, rd_en, pslverr}), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i]);
      bus_idle(1);
    end

    // penable without setup from IDLE is ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h008;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("nosetup_pready", 32'(pready), 32'd0);
      check("nosetup_strobe", 32'({wr_en, rd_en}), 32'd0);
      check("nosetup_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    bus_idle(1);

    // psel dropped after setup, then a stray access phase: no completion.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge clk);
    check("drop_pready", 32'(pready), 32'd0);
    check("drop_strobe", 32'({wr_en, rd_en}), 32'd0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1;
    @(negedge clk);
    check("drop_state", 32'(state_dbg), 32'(ST_IDLE));
    check("drop_pready2", 32'(pready), 32'd0);
    check("drop_strobe2", 32'({wr_en, rd_en}), 32'd0);
    bus_idle(1);

    // Back-to-back write then read: no idle cycle between them.
    wv = vecs[0];
    rv = vecs[1];
    xfer(wv);
    xfer(rv);
    check("b2b_gap", 32'(last_gap), 32'(B2B_GAP));
    bus_idle(1);

    // 300 error transfers: counter saturates.
    ev = vecs[3];
    for (int i = 0; i < 300; i++) xfer(ev);
    bus_idle(1);
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);

    // Reset in the middle of a write aborts it and clears the counter.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C;
    @(posedge clk); #1;
    penable = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pready", 32'(pready), 32'd0);
    check("midrst_strobe", 32'({wr_en, rd_en, pslverr}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = 8'd0;
    @(negedge clk);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("midrst_pready2", 32'(pready), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    bus_idle(1);
    xfer(vecs[8]);
    bus_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
